hamming_pipe_secded: RTL and testbench

HAMMING_PIPE_SECDED -- requirements
Module: hamming_pipe_secded

---
 rtl/hamming_pipe_secded_if.sv | 37 +++
 rtl/hamming_pipe_secded.sv | 156 +++++++++++++++
 tb/tb_hamming_pipe_secded.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hamming_pipe_secded_if.sv
// Handshake/data bundle for hamming_pipe_secded.
//   master : producer of input words and consumer of results (testbench / upstream)
//   slave  : the SECDED pipeline
// Signals:
//   in_valid/in_ready          input word handshake
//   message[NUM_BLK*4]         data, block k = message[4k+3:4k]
//   err_mask[NUM_BLK*8]        per-block codeword flip mask, bit i flips position i
//   out_valid/out_ready        result handshake
//   decoded_message            corrected data, same layout as message
//   corr_flags/uncorr_flags    per-block single-corrected / double-detected
//   error_positions[NUM_BLK*3] per-block corrected position, 0 if not corrected
interface hamming_pipe_secded_if #(
  parameter int NUM_BLK = 16
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_BLK*4-1:0]   message;
  logic [NUM_BLK*8-1:0]   err_mask;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_BLK*4-1:0]   decoded_message;
  logic [NUM_BLK-1:0]     corr_flags;
  logic [NUM_BLK-1:0]     uncorr_flags;
  logic [NUM_BLK*3-1:0]   error_positions;

  modport master (
    output in_valid, message, err_mask, out_ready,
    input  in_ready, out_valid, decoded_message, corr_flags, uncorr_flags,
           error_positions
  );

  modport slave (
    input  in_valid, message, err_mask, out_ready,
    output in_ready, out_valid, decoded_message, corr_flags, uncorr_flags,
           error_positions
  );
endinterface

// File: rtl/hamming_pipe_secded.sv
// hamming_pipe_secded: 3-stage extended Hamming(8,4) encode / error-inject /
// SECDED decode pipeline over NUM_BLK independent 4-bit blocks.
//   stage 1: encode + XOR err_mask
//   stage 2: syndrome + overall parity
//   stage 3: correct + flags (registered outputs)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, discards everything in flight
//   bus        hamming_pipe_secded_if.slave (handshakes, data, flags)
//   cnt_clr    synchronous clear of the error counters
//   corr_cnt   saturating count of corrected blocks
//   uncorr_cnt saturating count of double-error blocks
// Optional feature: define HAMMING_ERR_CNT_EN to enable the error counters;
// otherwise both counters read constant 0 and cnt_clr is ignored.
// Flow control is a global stall: every stage advances only when the output
// register is empty or being consumed.

// Per-block datapath; holds its own three pipeline registers.
module hamming_secded_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic [3:0] data,
  input  logic [7:0] mask,
  output logic [3:0] dec,
  output logic       corr,
  output logic       uncorr,
  output logic [2:0] pos
);
  logic [7:0] cw_enc;
  logic [7:0] s1_cw;
  logic [7:0] s2_cw;
  logic [2:0] s2_syn;
  logic       s2_par;
  logic [2:0] syn;
  logic [7:0] cw_fix;

  // Codeword position i is bit i; data at 3,5,6,7, parity at 1,2,4, overall at 0.
  always_comb begin
    cw_enc    = '0;
    cw_enc[3] = data[0];
    cw_enc[5] = data[1];
    cw_enc[6] = data[2];
    cw_enc[7] = data[3];
    cw_enc[1] = data[0] ^ data[1] ^ data[3];
    cw_enc[2] = data[0] ^ data[2] ^ data[3];
    cw_enc[4] = data[1] ^ data[2] ^ data[3];
    cw_enc[0] = ^cw_enc[7:1];
  end

  assign syn[0] = s1_cw[1] ^ s1_cw[3] ^ s1_cw[5] ^ s1_cw[7];
  assign syn[1] = s1_cw[2] ^ s1_cw[3] ^ s1_cw[6] ^ s1_cw[7];
  assign syn[2] = s1_cw[4] ^ s1_cw[5] ^ s1_cw[6] ^ s1_cw[7];

  // Overall parity set means an odd number of flips: treat as single error at
  // the syndrome position (syndrome 0 = the overall parity bit itself).
  always_comb begin
    cw_fix = s2_cw;
    if (s2_par) cw_fix[s2_syn] = ~s2_cw[s2_syn];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_cw  <= '0;
      s2_cw  <= '0;
      s2_syn <= '0;
      s2_par <= 1'b0;
      dec    <= '0;
      corr   <= 1'b0;
      uncorr <= 1'b0;
      pos    <= '0;
    end else if (adv) begin
      s1_cw  <= cw_enc ^ mask;
      s2_cw  <= s1_cw;
      s2_syn <= syn;
      s2_par <= ^s1_cw;
      dec    <= {cw_fix[7], cw_fix[6], cw_fix[5], cw_fix[3]};
      corr   <= s2_par;
      uncorr <= !s2_par && (s2_syn != 3'd0);
      pos    <= s2_par ? s2_syn : 3'd0;
    end
  end
endmodule

module hamming_pipe_secded #(
  parameter int NUM_BLK = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hamming_pipe_secded_if.slave  bus,
  input  logic                  cnt_clr,
  output logic [15:0]           corr_cnt,
  output logic [15:0]           uncorr_cnt
);
  localparam int STAGES = 3;

  logic [STAGES:0] vld_pipe;
  logic            adv;

  assign vld_pipe[0]   = bus.in_valid;
  assign adv           = bus.out_ready || !vld_pipe[STAGES];
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst)      vld_pipe[STAGES:1] <= '0;
    else if (adv) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_lane
    hamming_secded_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .data   (bus.message[4*k +: 4]),
      .mask   (bus.err_mask[8*k +: 8]),
      .dec    (bus.decoded_message[4*k +: 4]),
      .corr   (bus.corr_flags[k]),
      .uncorr (bus.uncorr_flags[k]),
      .pos    (bus.error_positions[3*k +: 3])
    );
  end

`ifdef HAMMING_ERR_CNT_EN
  logic out_fire;
  assign out_fire = vld_pipe[STAGES] && bus.out_ready;

  function automatic logic [5:0] popcnt(input logic [NUM_BLK-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NUM_BLK; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [5:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {11'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      corr_cnt   <= sat_add(corr_cnt,   popcnt(bus.corr_flags));
      uncorr_cnt <= sat_add(uncorr_cnt, popcnt(bus.uncorr_flags));
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif
endmodule

// File: tb/tb_hamming_pipe_secded.sv
// Directed bench for hamming_pipe_secded (NUM_BLK=16). Counter checks follow
// HAMMING_ERR_CNT_EN the same way the design does.
module tb_hamming_pipe_secded;
  localparam logic [63:0] M = 64'h0123456789ABCDEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_clr;
  logic [15:0] corr_cnt, uncorr_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  hamming_pipe_secded_if #(.NUM_BLK(16)) bus ();

  hamming_pipe_secded #(.NUM_BLK(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One word through an otherwise idle pipe; checks exact 3-cycle latency.
  task automatic run_vec(input string tag, input logic [63:0] msg, input logic [127:0] mask,
                         input logic [63:0] e_dec, input logic [15:0] e_corr,
                         input logic [15:0] e_unc, input logic [47:0] e_pos);
    bus.message  = msg;
    bus.err_mask = mask;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk({tag, ".early"}, 64'(bus.out_valid), 64'd0);
    step();
    chk({tag, ".vld"},  64'(bus.out_valid), 64'd1);
    chk({tag, ".dec"},  bus.decoded_message, e_dec);
    chk({tag, ".corr"}, 64'(bus.corr_flags), 64'(e_corr));
    chk({tag, ".unc"},  64'(bus.uncorr_flags), 64'(e_unc));
    chk({tag, ".pos"},  64'(bus.error_positions), 64'(e_pos));
    step();
  endtask

  logic [63:0] w [4];
  int sent, got, stall_left;
  bit seen;

  initial begin
    w[0] = 64'hFEDCBA9876543210;
    w[1] = 64'h0F1E2D3C4B5A6978;
    w[2] = 64'hDEADBEEFCAFEF00D;
    w[3] = 64'h0000FFFF5555AAAA;

    rst = 1'b1; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.message = '0; bus.err_mask = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst.dec",       bus.decoded_message, 64'd0);
    chk("rst.flags",     64'({bus.corr_flags, bus.uncorr_flags}), 64'd0);
    chk("rst.pos",       64'(bus.error_positions), 64'd0);
    chk("rst.cnt",       64'({corr_cnt, uncorr_cnt}), 64'd0);

    run_vec("clean", M, 128'h0, M, 16'h0000, 16'h0000, 48'h0);
    run_vec("single_d0", M, 128'h08, M, 16'h0001, 16'h0000, 48'h3);
    run_vec("dbl_p0", M, 128'h010600, M, 16'h0004, 16'h0002, 48'h0);
    run_vec("single_p7", M, {8'h80, 120'h0}, M, 16'h8000, 16'h0000, 48'hE00000000000);
    run_vec("dbl_0_7", M, {96'h0, 8'h81, 24'h0}, 64'h0123456789AB4DEF, 16'h0000, 16'h0008, 48'h0);
    run_vec("single_p5", M, {88'h0, 8'h20, 32'h0}, M, 16'h0010, 16'h0000, 48'h5000);
    run_vec("zero", 64'h0, 128'h0, 64'h0, 16'h0000, 16'h0000, 48'h0);

    // Back-to-back words with a 5-cycle output stall after the first result.
    sent = 0; got = 0; stall_left = 0; seen = 0;
    bus.err_mask = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (bus.out_valid && !seen) begin
        seen = 1;
        stall_left = 5;
      end
      bus.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      bus.in_valid = (sent < 4);
      bus.message  = (sent < 4) ? w[sent] : 64'h0;
      #1;
      if (!bus.out_ready && bus.out_valid) begin
        chk("stall.in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall.hold", bus.decoded_message, w[got]);
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        chk("order", bus.decoded_message, w[got]);
        got++;
      end
      step();
    end
    chk("stall.count", 64'(got), 64'd4);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();

`ifdef HAMMING_ERR_CNT_EN
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    bus.err_mask = 128'h0808;
    bus.message  = M;
    bus.in_valid = 1'b1;
    repeat (3) step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("cnt.six", 64'(corr_cnt), 64'd6);
    chk("cnt.unc0", 64'(uncorr_cnt), 64'd0);

    // Drive the counter to 16'hFFFE: 4095*16 + 7*2 = 65534.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    bus.err_mask = {16{8'h08}};
    bus.in_valid = 1'b1;
    repeat (4095) step();
    bus.err_mask = 128'h0808;
    repeat (7) step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("cnt.fffe", 64'(corr_cnt), 64'hFFFE);

    run_vec("cnt.sat_word", M, 128'h060808, M, 16'h0003, 16'h0004, 48'h1B);
    chk("cnt.ffff", 64'(corr_cnt), 64'hFFFF);
    chk("cnt.unc1", 64'(uncorr_cnt), 64'd1);

    // Clear coinciding with an output handshake wins.
    bus.err_mask = 128'h0808;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    chk("clr.vld", 64'(bus.out_valid), 64'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr.corr", 64'(corr_cnt), 64'd0);
    chk("clr.unc", 64'(uncorr_cnt), 64'd0);
`else
    bus.err_mask = 128'h060808;
    bus.message  = M;
    bus.in_valid = 1'b1;
    cnt_clr = 1'b1;
    repeat (2) step();
    bus.in_valid = 1'b0; cnt_clr = 1'b0;
    repeat (4) step();
    chk("nocnt.corr", 64'(corr_cnt), 64'd0);
    chk("nocnt.unc", 64'(uncorr_cnt), 64'd0);
`endif

    // Reset while a word sits stalled at the output.
    bus.out_ready = 1'b0;
    bus.message   = 64'h1234;
    bus.err_mask  = 128'h08;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("rst_stall.vld", 64'(bus.out_valid), 64'd1);
    chk("rst_stall.dec", bus.decoded_message, 64'h1234);
    rst = 1'b1;
    step();
    chk("rst_stall.drop", 64'(bus.out_valid), 64'd0);
    chk("rst_stall.cnt", 64'({corr_cnt, uncorr_cnt}), 64'd0);
    chk("rst_stall.dec0", bus.decoded_message, 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_stall.ghost", 64'(bus.out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
